r_router_n: RTL and testbench
=============================

R_ROUTER_N -- requirements
Module: r_router_n

Interface
REQ-001 Parameter NS, default 5: number of slave read channels (1..8).
REQ-002 Parameter DW, default 32: read data width.
REQ-003 Parameter SELW, default 3: select code width; must satisfy 2**SELW > NS.
REQ-004 Parameter DEPTH, default 4: outstanding-transaction FIFO depth (power of 2, >=2).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-high.
REQ-008 ar_push  in  1  AR accepted upstream this cycle; enqueue ar_sel/ar_len.
REQ-009 ar_sel  in  SELW  target slave index; values >= NS are unmapped.
REQ-010 ar_len  in  8  AXI burst length (beats - 1).
REQ-011 ar_full  out  1  FIFO full; upstream must not push.
REQ-012 s_rdata  in  NS*DW  slave i read data at bits [i*DW +: DW].
REQ-013 s_rresp  in  NS*2  slave i response at [i*2 +: 2].
REQ-014 s_rlast, s_rvalid  in  NS each  per-slave last/valid.
REQ-015 s_rready  out  NS  per-slave ready.
REQ-016 m_rdata  out  DW; m_rresp  out  2; m_rlast, m_rvalid  out  1 each: registered master R channel.
REQ-017 m_rready  in  1  master ready.

Function
REQ-018 Select FIFO SHALL store {sel, len} in order; push when ar_push and !ar_full; ar_push while full SHALL be ignored (no state change).
REQ-019 FIFO head SHALL select the active source; with the FIFO empty, all s_rready = 0 and no beat enters the output stage.
REQ-020 Only the selected slave SHALL see s_rready high; s_rready[head] = output-stage can_accept; all others 0.
REQ-021 Unmapped head (sel >= NS) SHALL engage the internal DECERR source: ar_len+1 beats, rdata = 0, rresp = 2'b11, rlast on final beat only; beat counter 8-bit, counting up from 0 to len.
REQ-022 Head SHALL pop when a beat with rlast = 1 is accepted into the output stage from the active source; a push and a pop in the same cycle SHALL both take effect (count unchanged).
REQ-023 Beats from a mapped slave with rlast = 0 SHALL not pop; slave rlast is trusted, len unused for mapped slaves.
REQ-024 Output stage: 2-entry skid buffer; m_* registered; latency source-handshake -> m_rvalid = 1 cycle; sustained 1 beat/cycle when m_rready held high.
REQ-025 can_accept SHALL depend only on registered skid occupancy (no combinational path m_rready -> s_rready).
REQ-026 m_rvalid once high SHALL hold, with m_rdata/m_rresp/m_rlast stable, until m_rready.
REQ-027 Head switch after pop SHALL allow a beat from the next source in the following cycle (no bubble beyond 1 cycle).
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; ar_full = (count == DEPTH).

Reset
REQ-029 On rst: FIFO empty, ar_full = 0, beat counter 0, skid empty, m_rvalid = 0, m_rlast = 0, m_rdata = 0, m_rresp = 0, s_rready = 0.
REQ-030 Reset mid-burst SHALL discard all queued and in-flight beats; first post-reset beat requires a new ar_push.

Structure
REQ-031 Shared package SHALL hold RESP_OKAY = 2'b00, RESP_DECERR = 2'b11, the {sel, len} entry typedef.
REQ-032 Skid buffer SHALL be one sub-module, r_skid, parametrised on DW+3 payload bits.

Verification
REQ-033 Push sel=2,len=3; slave 2 drives 4 beats, data 0xA0..0xA3, m_rready=1 -> m_r* shows 4 beats, rlast on 0xA3, FIFO empty after.
REQ-034 Push sel=7,len=1 (NS=5) -> 2 beats rdata=0, rresp=2'b11, rlast on second; no s_rready asserted.
REQ-035 Push DEPTH entries then one more -> ar_full=1, extra push ignored, count = DEPTH.
REQ-036 Back-to-back sel=0 len=0, sel=4 len=0 with m_rready toggling 1/0 -> order preserved, data stable while m_rvalid && !m_rready.
REQ-037 Assert rst during beat 2 of a len=3 burst -> all outputs at reset values next cycle, queued entries lost.
REQ-038 Slave 1 rvalid high while head = slave 3 -> s_rready[1] = 0, no slave-1 beat forwarded.

Source files
------------

// File: rtl/r_router_n_pkg.sv
// Shared types and constants for the R-channel router.
package r_router_n_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Select field is stored at a fixed width wide enough for any legal SELW.
  localparam int SEL_MAX_W = 8;

  typedef struct packed {
    logic [SEL_MAX_W-1:0] sel;
    logic [7:0]           len;
  } rd_entry_t;

  function automatic rd_entry_t make_entry(input logic [SEL_MAX_W-1:0] sel,
                                           input logic [7:0] len);
    rd_entry_t e;
    e.sel = sel;
    e.len = len;
    return e;
  endfunction

endpackage

// File: rtl/r_router_n_skid.sv
// Two-entry skid buffer with a registered output stage. Input ready is a
// pure function of registered occupancy, so out_ready_i never reaches
// in_ready_o combinationally.
module r_skid #(
  parameter int W = 35
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic         skid_valid_q;
  logic [W-1:0] skid_data_q;
  logic         in_fire_s;

  assign in_ready_o  = !skid_valid_q;
  assign in_fire_s   = in_valid_i && !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Refill the output register from the skid entry first, then from the input;
  // park an input beat in the skid entry while the output is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else if (in_fire_s) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data_i;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire_s) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data_i;
    end
  end

endmodule

// File: rtl/r_router_n.sv
// Read-data router: an in-order FIFO of {sel, len} picks which slave R
// channel feeds the master; unmapped selects are answered by an internal
// DECERR source that emits len+1 zero-data beats.
module r_router_n
  import r_router_n_pkg::*;
#(
  parameter int NS    = 5,
  parameter int DW    = 32,
  parameter int SELW  = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ar_push,
  input  logic [SELW-1:0]  ar_sel,
  input  logic [7:0]       ar_len,
  output logic             ar_full,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS*2-1:0]  s_rresp,
  input  logic [NS-1:0]    s_rlast,
  input  logic [NS-1:0]    s_rvalid,
  output logic [NS-1:0]    s_rready,
  output logic [DW-1:0]    m_rdata,
  output logic [1:0]       m_rresp,
  output logic             m_rlast,
  output logic             m_rvalid,
  input  logic             m_rready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DW + 3;
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);
  localparam logic [SEL_MAX_W-1:0] NS_SEL   = SEL_MAX_W'(NS);

  rd_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      beat_q;

  rd_entry_t       head_s;
  logic            empty_s, mapped_s, push_s, pop_s;
  logic            can_accept_s, beat_fire_s;
  logic            src_valid_s, src_last_s;
  logic [DW-1:0]   src_data_s;
  logic [1:0]      src_resp_s;
  logic [PW-1:0]   skid_out_s;

  assign ar_full     = (count_q == FULL_CNT);
  assign empty_s     = (count_q == '0);
  assign head_s      = mem_q[rptr_q];
  assign mapped_s    = (head_s.sel < NS_SEL);
  assign push_s      = ar_push && !ar_full;
  assign beat_fire_s = src_valid_s && can_accept_s;
  assign pop_s       = beat_fire_s && src_last_s;

  // Pick the beat source named by the FIFO head (slave channel or DECERR).
  always_comb begin
    src_valid_s = 1'b0;
    src_last_s  = 1'b0;
    src_data_s  = '0;
    src_resp_s  = RESP_OKAY;
    if (!empty_s && !mapped_s) begin
      src_valid_s = 1'b1;
      src_resp_s  = RESP_DECERR;
      src_last_s  = (beat_q == head_s.len);
    end else if (!empty_s) begin
      for (int i = 0; i < NS; i++) begin
        if (head_s.sel == SEL_MAX_W'(i)) begin
          src_valid_s = s_rvalid[i];
          src_last_s  = s_rlast[i];
          src_data_s  = s_rdata[i*DW +: DW];
          src_resp_s  = s_rresp[i*2 +: 2];
        end else begin
          src_valid_s = src_valid_s;
        end
      end
    end else begin
      src_valid_s = 1'b0;
    end
  end

  // Only the slave at the head of the queue ever sees ready.
  for (genvar g = 0; g < NS; g++) begin : g_rready
    assign s_rready[g] = !empty_s && (head_s.sel == SEL_MAX_W'(g)) && can_accept_s;
  end

  // Queue bookkeeping: pointers wrap naturally, push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= make_entry(SEL_MAX_W'(ar_sel), ar_len);
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_s) rptr_q <= rptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // DECERR beat counter: counts 0..len, back to 0 on the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= 8'd0;
    end else if (beat_fire_s && !empty_s && !mapped_s) begin
      beat_q <= src_last_s ? 8'd0 : beat_q + 8'd1;
    end
  end

  r_skid #(.W(PW)) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (src_valid_s),
    .in_ready_o  (can_accept_s),
    .in_data_i   ({src_resp_s, src_last_s, src_data_s}),
    .out_valid_o (m_rvalid),
    .out_ready_i (m_rready),
    .out_data_o  (skid_out_s)
  );

  assign {m_rresp, m_rlast, m_rdata} = skid_out_s;

endmodule

// File: tb/tb_r_router_n.sv
// Directed bench for r_router_n: a per-cycle vector table plus hand-written
// sequences for full FIFO, stalled output, and mid-burst reset.
module tb_r_router_n;

  localparam int NS = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ar_push;
  logic [2:0]    ar_sel;
  logic [7:0]    ar_len;
  logic          ar_full;
  logic [159:0]  s_rdata;
  logic [9:0]    s_rresp;
  logic [4:0]    s_rlast, s_rvalid, s_rready;
  logic [31:0]   m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast, m_rvalid, m_rready;

  int n_tests = 0;
  int n_fail  = 0;

  r_router_n #(.NS(NS), .DW(DW), .SELW(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ar_push(ar_push), .ar_sel(ar_sel), .ar_len(ar_len),
    .ar_full(ar_full), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [2:0]  sel;
    logic [7:0]  len;
    logic [4:0]  sv;
    logic [31:0] d;
    logic        lst;
    logic [4:0]  e_srr;
    logic        e_v;
    logic [31:0] e_d;
    logic [1:0]  e_r;
    logic        e_l;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic push, input logic [2:0] sel, input logic [7:0] len,
                              input logic [4:0] sv, input logic [31:0] d, input logic lst,
                              input logic [4:0] e_srr, input logic e_v, input logic [31:0] e_d,
                              input logic [1:0] e_r, input logic e_l);
    vec_t v;
    v.push = push; v.sel = sel; v.len = len; v.sv = sv; v.d = d; v.lst = lst;
    v.e_srr = e_srr; v.e_v = e_v; v.e_d = e_d; v.e_r = e_r; v.e_l = e_l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rvalid"},  64'(m_rvalid), 64'd0);
    chk({tag, "_rdata"},   64'(m_rdata),  64'd0);
    chk({tag, "_rresp"},   64'(m_rresp),  64'd0);
    chk({tag, "_rlast"},   64'(m_rlast),  64'd0);
    chk({tag, "_full"},    64'(ar_full),  64'd0);
    chk({tag, "_srready"}, 64'(s_rready), 64'd0);
  endtask

  logic [31:0] got [4];
  int          n_got;
  logic        prev_hold;
  logic [31:0] prev_d;

  initial begin
    rst = 1'b1; ar_push = 1'b0; ar_sel = 3'd0; ar_len = 8'd0;
    s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rvalid = '0; m_rready = 1'b1;

    // Vector table: per-cycle inputs and the outputs expected in that cycle.
    vecs[0]  = mk(1'b1, 3'd2, 8'd3, 5'b00000, 32'h0,  1'b0, 5'b00000, 1'b0, 32'h0,  2'b00, 1'b0);
    vecs[1]  = mk(1'b0, 3'd0, 8'd0, 5'b00100, 32'hA0, 1'b0, 5'b00100, 1'b0, 32'h0,  2'b00, 1'b0);
    vecs[2]  = mk(1'b0, 3'd0, 8'd0, 5'b00100, 32'hA1, 1'b0, 5'b00100, 1'b1, 32'hA0, 2'b00, 1'b0);
    vecs[3]  = mk(1'b0, 3'd0, 8'd0, 5'b00100, 32'hA2, 1'b0, 5'b00100, 1'b1, 32'hA1, 2'b00, 1'b0);
    vecs[4]  = mk(1'b0, 3'd0, 8'd0, 5'b00100, 32'hA3, 1'b1, 5'b00100, 1'b1, 32'hA2, 2'b00, 1'b0);
    vecs[5]  = mk(1'b0, 3'd0, 8'd0, 5'b00000, 32'h0,  1'b0, 5'b00000, 1'b1, 32'hA3, 2'b00, 1'b1);
    vecs[6]  = mk(1'b1, 3'd7, 8'd1, 5'b00000, 32'h0,  1'b0, 5'b00000, 1'b0, 32'h0,  2'b00, 1'b0);
    vecs[7]  = mk(1'b0, 3'd0, 8'd0, 5'b00000, 32'h0,  1'b0, 5'b00000, 1'b0, 32'h0,  2'b00, 1'b0);
    vecs[8]  = mk(1'b0, 3'd0, 8'd0, 5'b00000, 32'h0,  1'b0, 5'b00000, 1'b1, 32'h0,  2'b11, 1'b0);
    vecs[9]  = mk(1'b0, 3'd0, 8'd0, 5'b00000, 32'h0,  1'b0, 5'b00000, 1'b1, 32'h0,  2'b11, 1'b1);
    vecs[10] = mk(1'b1, 3'd3, 8'd0, 5'b00010, 32'hBB, 1'b1, 5'b00000, 1'b0, 32'h0,  2'b00, 1'b0);
    vecs[11] = mk(1'b0, 3'd0, 8'd0, 5'b00010, 32'hBB, 1'b1, 5'b01000, 1'b0, 32'h0,  2'b00, 1'b0);
    vecs[12] = mk(1'b0, 3'd0, 8'd0, 5'b00010, 32'hBB, 1'b1, 5'b01000, 1'b0, 32'h0,  2'b00, 1'b0);
    vecs[13] = mk(1'b0, 3'd0, 8'd0, 5'b01000, 32'hC3, 1'b1, 5'b01000, 1'b0, 32'h0,  2'b00, 1'b0);
    vecs[14] = mk(1'b0, 3'd0, 8'd0, 5'b00000, 32'h0,  1'b0, 5'b00000, 1'b1, 32'hC3, 2'b00, 1'b1);
    vecs[15] = mk(1'b0, 3'd0, 8'd0, 5'b00000, 32'h0,  1'b0, 5'b00000, 1'b0, 32'h0,  2'b00, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk_reset_state("reset");

    // Table: single burst, DECERR burst, off-head slave ignored.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ar_push = vecs[i].push; ar_sel = vecs[i].sel; ar_len = vecs[i].len;
      s_rvalid = vecs[i].sv; s_rdata = {5{vecs[i].d}}; s_rlast = {5{vecs[i].lst}};
      m_rready = 1'b1;
      #1;
      chk($sformatf("v%0d_srready", i), 64'(s_rready), 64'(vecs[i].e_srr));
      chk($sformatf("v%0d_full", i),    64'(ar_full),  64'd0);
      chk($sformatf("v%0d_rvalid", i),  64'(m_rvalid), 64'(vecs[i].e_v));
      if (vecs[i].e_v) begin
        chk($sformatf("v%0d_rdata", i), 64'(m_rdata), 64'(vecs[i].e_d));
        chk($sformatf("v%0d_rresp", i), 64'(m_rresp), 64'(vecs[i].e_r));
        chk($sformatf("v%0d_rlast", i), 64'(m_rlast), 64'(vecs[i].e_l));
      end
    end

    // Fill to DEPTH, push once more while full, then drain in order.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ar_push = 1'b1; ar_sel = 3'(k); ar_len = 8'd0; s_rvalid = '0; s_rlast = '1;
      #1 chk($sformatf("fill%0d_full", k), 64'(ar_full), 64'd0);
    end
    @(negedge clk); ar_sel = 3'd4;
    #1 chk("full_at_depth", 64'(ar_full), 64'd1);
    @(negedge clk); ar_push = 1'b0;
    #1;
    chk("full_after_extra", 64'(ar_full), 64'd1);
    chk("head_after_extra", 64'(s_rready), 64'b00001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_rvalid = 5'(1 << k); s_rdata[k*32 +: 32] = 32'hD0 + 32'(k);
      #1;
      chk($sformatf("drain%0d_srready", k), 64'(s_rready), 64'(1 << k));
      if (k > 0) chk($sformatf("drain%0d_rdata", k), 64'(m_rdata), 64'(32'hD0 + 32'(k - 1)));
    end
    @(negedge clk); s_rvalid = '0;
    #1;
    chk("drain_empty_srready", 64'(s_rready), 64'd0);
    chk("drain_last_rdata", 64'(m_rdata), 64'hD3);
    chk("drain_full", 64'(ar_full), 64'd0);
    @(negedge clk);
    #1 chk("drain_idle_rvalid", 64'(m_rvalid), 64'd0);

    // Back-to-back bursts with m_rready toggling: order and hold stability.
    @(negedge clk); ar_push = 1'b1; ar_sel = 3'd0; ar_len = 8'd0;
    s_rdata[0 +: 32] = 32'hE0; s_rdata[128 +: 32] = 32'hF4;
    s_rlast = '1; s_rvalid = 5'b10001;
    @(negedge clk); ar_sel = 3'd4;
    n_got = 0; prev_hold = 1'b0; prev_d = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); ar_push = 1'b0; m_rready = (c % 2 == 0);
      #1;
      if (prev_hold) begin
        chk($sformatf("stall%0d_rvalid", c), 64'(m_rvalid), 64'd1);
        chk($sformatf("stall%0d_rdata", c), 64'(m_rdata), 64'(prev_d));
      end
      if (m_rvalid && m_rready && n_got < 4) begin
        got[n_got] = m_rdata;
        n_got++;
      end
      prev_hold = m_rvalid && !m_rready;
      prev_d = m_rdata;
    end
    chk("order_count", 64'(n_got), 64'd2);
    chk("order_first", 64'(got[0]), 64'hE0);
    chk("order_second", 64'(got[1]), 64'hF4);

    // Reset in the middle of a len=3 burst with a second entry queued.
    @(negedge clk); m_rready = 1'b1; s_rvalid = 5'b00010; s_rlast = '0;
    s_rdata[32 +: 32] = 32'hB0; ar_push = 1'b1; ar_sel = 3'd1; ar_len = 8'd3;
    @(negedge clk); ar_sel = 3'd2; ar_len = 8'd0;
    @(negedge clk); ar_push = 1'b0;
    #1 chk("pre_rst_rvalid", 64'(m_rvalid), 64'd1);
    @(negedge clk); rst = 1'b1;
    #1 chk_reset_state("midrst");
    @(negedge clk); rst = 1'b0; s_rvalid = 5'b00110; s_rlast = '1; s_rdata[64 +: 32] = 32'hC2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst%0d_srready", c), 64'(s_rready), 64'd0);
      chk($sformatf("postrst%0d_rvalid", c), 64'(m_rvalid), 64'd0);
    end
    @(negedge clk); ar_push = 1'b1; ar_sel = 3'd1; ar_len = 8'd0;
    @(negedge clk); ar_push = 1'b0;
    #1 chk("newpush_srready", 64'(s_rready), 64'b00010);
    @(negedge clk);
    #1;
    chk("newpush_rvalid", 64'(m_rvalid), 64'd1);
    chk("newpush_rdata", 64'(m_rdata), 64'hB0);
    chk("newpush_rlast", 64'(m_rlast), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
